// File: rtl/ec_pkg.sv
// Shared types and modular-arithmetic helpers for the elliptic-curve scalar multiplier.
// Values are carried at the widest supported width (16 bits); callers zero-extend and truncate.
package ec_pkg;

    localparam int EC_MW = 16;

    typedef logic [EC_MW-1:0] ec_word_t;

    typedef enum logic [3:0] {
        IDLE,
        DBL_CHK,
        DBL_INV,
        DBL_PT,
        ADD_CHK,
        ADD_INV,
        ADD_PT,
        NEXT,
        DONE
    } ec_state_t;

    typedef struct packed {
        ec_word_t x;
        ec_word_t y;
        logic     inf;
    } ec_point_t;

    // Operands are always already reduced below p, so one conditional subtract suffices.
    function automatic ec_word_t mod_add(input ec_word_t x, input ec_word_t y, input ec_word_t p);
        logic [EC_MW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, p}) s = s - {1'b0, p};
        return EC_MW'(s);
    endfunction

    function automatic ec_word_t mod_sub(input ec_word_t x, input ec_word_t y, input ec_word_t p);
        logic [EC_MW:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[EC_MW]) d = d + {1'b0, p};
        return EC_MW'(d);
    endfunction

    function automatic ec_word_t mod_mul(input ec_word_t x, input ec_word_t y, input ec_word_t p);
        logic [2*EC_MW-1:0] prod;
        prod = {{EC_MW{1'b0}}, x} * {{EC_MW{1'b0}}, y};
        return EC_MW'(prod % {{EC_MW{1'b0}}, p});
    endfunction

endpackage

// File: rtl/mod_inv.sv
// Modular inverse by binary extended Euclid, one halving per cycle; done is a one-cycle pulse.
// With EC_CONST_TIME_EN defined the run is padded so done always arrives 2W+2 cycles after start.
module mod_inv #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] p,
    output logic         done,
    output logic [W-1:0] inv
);

`ifdef EC_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    localparam int CW   = $clog2(2*W + 1);
    localparam int LAST = 2*W;

    logic          run_q, run_d;
    logic [W-1:0]  u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, pm_q, pm_d, inv_q, inv_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          finished, end_now;

    function automatic logic [W-1:0] halve_mod(input logic [W-1:0] x, input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, x} + (x[0] ? {1'b0, m} : '0);
        return W'(s >> 1);
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] m);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[W]) d = d + {1'b0, m};
        return W'(d);
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            run_q  <= 1'b0;
            u_q    <= '0;
            v_q    <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            pm_q   <= '0;
            inv_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            u_q    <= u_d;
            v_q    <= v_d;
            x1_q   <= x1_d;
            x2_q   <= x2_d;
            pm_q   <= pm_d;
            inv_q  <= inv_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Invariants: x1*a == u and x2*a == v (mod p); every step halves u*v at least once.
    always_comb begin
        run_d    = run_q;
        u_d      = u_q;
        v_d      = v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        pm_d     = pm_q;
        inv_d    = inv_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        finished = (u_q == W'(1)) || (v_q == W'(1));
        end_now  = CONST_TIME ? (cnt_q == CW'(LAST)) : finished;
        if (!run_q) begin
            if (start) begin
                run_d = 1'b1;
                u_d   = a;
                v_d   = p;
                pm_d  = p;
                x1_d  = W'(1);
                x2_d  = '0;
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (end_now) begin
                run_d  = 1'b0;
                done_d = 1'b1;
                inv_d  = (u_q == W'(1)) ? x1_q : x2_q;
            end else if (!finished) begin
                if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = halve_mod(x1_q, pm_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = halve_mod(x2_q, pm_q);
                end else if (u_q >= v_q) begin
                    u_d  = (u_q - v_q) >> 1;
                    x1_d = halve_mod(sub_mod(x1_q, x2_q, pm_q), pm_q);
                end else begin
                    v_d  = (v_q - u_q) >> 1;
                    x2_d = halve_mod(sub_mod(x2_q, x1_q, pm_q), pm_q);
                end
            end
        end
    end

    assign done = done_q;
    assign inv  = inv_q;

endmodule

// File: rtl/ec_scalar_mult.sv
// Elliptic-curve scalar multiplier R = k*G, MSB-first double-and-add in affine coordinates.
// Defining EC_CONST_TIME_EN makes every bit run a full double and a (possibly dummy) add.
module ec_scalar_mult #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         start,
    input  logic [W-1:0] k,
    input  logic [W-1:0] Gx,
    input  logic [W-1:0] Gy,
    input  logic [W-1:0] p,
    input  logic [W-1:0] a,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Rx,
    output logic [W-1:0] Ry,
    output logic         inf
);
    import ec_pkg::*;

`ifdef EC_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    localparam int IW = $clog2(W);

    ec_state_t     state_q, state_d;
    logic [W-1:0]  k_q, k_d;
    ec_word_t      gx_q, gx_d, gy_q, gy_d, p_q, p_d, a_q, a_d, lam_q, lam_d;
    ec_point_t     r_q, r_d;
    logic [IW-1:0] i_q, i_d;
    logic          add_q, add_d, dummy_q, dummy_d;
    logic [W-1:0]  rx_q, rx_d, ry_q, ry_d;
    logic          inf_q, inf_d, done_q, done_d;

    logic          inv_start, inv_done, add_skip;
    logic [W-1:0]  inv_a, inv_res, p_w;
    ec_word_t      inv_w, rx_sq, lam_dbl, lam_add, lam_sq, x_dbl, y_dbl, x_add, y_add;

    assign p_w   = W'(p_q);
    assign inv_w = EC_MW'(inv_res);

    mod_inv #(.W(W)) u_inv (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .start  (inv_start),
        .a      (inv_a),
        .p      (p_w),
        .done   (inv_done),
        .inv    (inv_res)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            p_q     <= '0;
            a_q     <= '0;
            lam_q   <= '0;
            r_q     <= '0;
            i_q     <= '0;
            add_q   <= 1'b0;
            dummy_q <= 1'b0;
            rx_q    <= '0;
            ry_q    <= '0;
            inf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            p_q     <= p_d;
            a_q     <= a_d;
            lam_q   <= lam_d;
            r_q     <= r_d;
            i_q     <= i_d;
            add_q   <= add_d;
            dummy_q <= dummy_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            inf_q   <= inf_d;
            done_q  <= done_d;
        end
    end

    // Slopes use the fresh inverse; new coordinates use the latched slope.
    always_comb begin
        rx_sq   = mod_mul(r_q.x, r_q.x, p_q);
        lam_dbl = mod_mul(mod_add(mod_add(mod_add(rx_sq, rx_sq, p_q), rx_sq, p_q), a_q, p_q),
                          inv_w, p_q);
        lam_add = mod_mul(mod_sub(gy_q, r_q.y, p_q), inv_w, p_q);
        lam_sq  = mod_mul(lam_q, lam_q, p_q);
        x_dbl   = mod_sub(lam_sq, mod_add(r_q.x, r_q.x, p_q), p_q);
        x_add   = mod_sub(mod_sub(lam_sq, r_q.x, p_q), gx_q, p_q);
        y_dbl   = mod_sub(mod_mul(lam_q, mod_sub(r_q.x, x_dbl, p_q), p_q), r_q.y, p_q);
        y_add   = mod_sub(mod_mul(lam_q, mod_sub(r_q.x, x_add, p_q), p_q), r_q.y, p_q);
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        p_d       = p_q;
        a_d       = a_q;
        lam_d     = lam_q;
        r_d       = r_q;
        i_d       = i_q;
        add_d     = add_q;
        dummy_d   = dummy_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        inf_d     = inf_q;
        done_d    = 1'b0;
        inv_start = 1'b0;
        inv_a     = '0;
        add_skip  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d     = k;
                    gx_d    = EC_MW'(Gx);
                    gy_d    = EC_MW'(Gy);
                    p_d     = EC_MW'(p);
                    a_d     = EC_MW'(a);
                    r_d     = '{x: '0, y: '0, inf: 1'b1};
                    i_d     = IW'(W - 1);
                    state_d = DBL_CHK;
                end
            end
            DBL_CHK: begin
                add_d   = 1'b0;
                dummy_d = 1'b0;
                inv_a   = W'(mod_add(r_q.y, r_q.y, p_q));
                if (r_q.inf || r_q.y == '0) begin
                    r_d = '{x: '0, y: '0, inf: 1'b1};
                    if (CONST_TIME) begin
                        dummy_d   = 1'b1;
                        inv_start = 1'b1;
                        state_d   = DBL_INV;
                    end else begin
                        state_d = ADD_CHK;
                    end
                end else begin
                    inv_start = 1'b1;
                    state_d   = DBL_INV;
                end
            end
            DBL_INV: begin
                if (inv_done) begin
                    lam_d   = lam_dbl;
                    state_d = DBL_PT;
                end
            end
            DBL_PT: begin
                if (!dummy_q) r_d = '{x: x_dbl, y: y_dbl, inf: 1'b0};
                state_d = add_q ? NEXT : ADD_CHK;
            end
            // R == G is folded into the doubling datapath; add_q routes its result to NEXT.
            ADD_CHK: begin
                dummy_d = 1'b0;
                inv_a   = W'(mod_sub(gx_q, r_q.x, p_q));
                if (!k_q[i_q]) begin
                    add_skip = 1'b1;
                end else if (r_q.inf) begin
                    r_d      = '{x: gx_q, y: gy_q, inf: 1'b0};
                    add_skip = 1'b1;
                end else if (r_q.x == gx_q && r_q.y == gy_q && r_q.y != '0) begin
                    add_d     = 1'b1;
                    inv_a     = W'(mod_add(r_q.y, r_q.y, p_q));
                    inv_start = 1'b1;
                    state_d   = DBL_INV;
                end else if (r_q.x == gx_q) begin
                    r_d      = '{x: '0, y: '0, inf: 1'b1};
                    add_skip = 1'b1;
                end else begin
                    inv_start = 1'b1;
                    state_d   = ADD_INV;
                end
                if (add_skip) begin
                    if (CONST_TIME) begin
                        dummy_d   = 1'b1;
                        inv_start = 1'b1;
                        state_d   = ADD_INV;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            ADD_INV: begin
                if (inv_done) begin
                    lam_d   = lam_add;
                    state_d = ADD_PT;
                end
            end
            ADD_PT: begin
                if (!dummy_q) r_d = '{x: x_add, y: y_add, inf: 1'b0};
                state_d = NEXT;
            end
            NEXT: begin
                if (i_q == '0) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q - IW'(1);
                    state_d = DBL_CHK;
                end
            end
            DONE: begin
                rx_d    = r_q.inf ? '0 : W'(r_q.x);
                ry_d    = r_q.inf ? '0 : W'(r_q.y);
                inf_d   = r_q.inf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign Rx   = rx_q;
    assign Ry   = ry_q;
    assign inf  = inf_q;

endmodule
